op_encoder: RTL and testbench
=============================

Name: op_encoder

Overview:
- Front end of the cursor/operation path: turns six raw push-buttons into the 3-bit operation code stream consumed by the cursor/selection logic.
- Each accepted press produces a code for exactly one clock; the code is 0 on every other cycle.
- Performs synchronisation, per-button debounce, press-edge detection, priority arbitration and auto-repeat for the four direction buttons.
- A lock input from the elimination logic suppresses all operations while a board update is in progress.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised button level must differ from its stable level before the stable level flips. Minimum 1.
- REPEAT_DELAY, 25000000: cycles a direction button is held, counted from its emitted press, before the first repeat.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeats. Minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn  in  6  raw asynchronous buttons, active high: [0] select, [1] cancel, [2] left, [3] right, [4] up, [5] down.
- lock  in  1  synchronous to clk; 1 = suppress all output and repeat activity.
- operation  out  3  registered operation code, one-cycle pulse: 0 none, 1 select, 2 cancel, 3 left, 4 right, 5 up, 6 down. Code 7 is never driven.

Behaviour:
- Reset (async assert, removal sampled by clk):
  - operation=0.
  - Sync flops, stable levels and all counters = 0.
  - FSM = IDLE.
  - A button already held when reset releases counts as a press only after completing debounce.
- Synchronise: 2-flop synchroniser per button; sync[i] is btn[i] delayed 2 edges.
- Debounce, per button:
  - Counter clears whenever sync[i] == stable[i].
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES, stable[i] takes sync[i] and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Press event: press[i] = stable[i] rises (0 to 1). It is a single-cycle, combinational event.
- Arbitration: if several press bits are set in one cycle, the lowest index wins. Losers are dropped, not queued.
- Output: operation registers the winner code (index+1) on the edge after the press event, and returns to 0 on the following edge.
  - Latency: a clean raw step sampled at edge k appears on operation after edge k+2+DEBOUNCE_CYCLES+1, held one cycle.
- Auto-repeat FSM (tracks one button index trk):
  - IDLE: on an emitted direction press (code 3-6) set trk to that index, clear the timer, go to DELAY. Select/cancel presses stay in IDLE.
  - DELAY: the timer counts each cycle. When it reaches REPEAT_DELAY, emit code trk+1 (same single-cycle register), clear the timer, go to REPEAT.
  - REPEAT: the timer counts. When it reaches REPEAT_PERIOD, emit code trk+1 and clear the timer.
  - In DELAY or REPEAT, stable[trk]=0 (release) returns the FSM to IDLE on that edge with no emission.
  - In DELAY or REPEAT, any new emitted press preempts:
    - a direction press retargets trk and restarts DELAY;
    - select/cancel returns the FSM to IDLE.
  - A fresh press and a repeat due in the same cycle: the press wins and the repeat is dropped.
  - Timer width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
- Lock:
  - While lock=1, operation is forced to 0 on the next edge.
  - Press events occurring while locked are discarded.
  - The FSM is forced to IDLE.
  - Debounce continues, so stable levels stay correct. A button held through lock is therefore not re-emitted on unlock until it is released and pressed again.
- Reset asserted mid-debounce or mid-repeat: everything clears immediately. No pulse is emitted after reset release for a partially debounced press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Clean press: btn[0]=1 held 20 cycles from edge 0 -> operation=1 for exactly one cycle after edge 7, 0 elsewhere; release produces no code.
- Bounce: btn[2] toggles every 2 cycles for 12 cycles, then holds 1 -> exactly one operation=3 pulse, occurring 7 edges after the final rising transition.
- Auto-repeat: btn[5] held 40 cycles -> operation=6 at the first emission (edge E), then at E+10, E+15, E+20 …; stops within 1 cycle of stable release.
- Simultaneous press: btn[1] and btn[3] rise on the same edge -> a single operation=2, no 4, FSM stays IDLE (no repeats).
- Preempt: hold btn[4]; after 2 repeats, press btn[3] -> operation=4 once, then repeats of 4 every 5 cycles after a 10-cycle delay; no further 5s.
- Lock/reset: lock=1 while btn[0] is pressed -> operation stays 0, and no pulse after lock drops while btn[0] is still held. Separately, rst pulsed mid-repeat -> operation=0 immediately and no output until a new debounced press.

Source files
------------

// File: rtl/op_encoder.sv
// op_encoder: six push-buttons to a one-cycle operation code stream, with
// synchronisation, debounce, lowest-index priority and direction auto-repeat.
module op_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn,
  input  logic       lock,
  output logic [2:0] operation
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TM_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TM_W-1:0] DELAY_LAST  = TM_W'(REPEAT_DELAY);
  localparam logic [TM_W-1:0] PERIOD_LAST = TM_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  logic [5:0]            sync1_q, sync1_d;
  logic [5:0]            sync2_q, sync2_d;
  logic [5:0]            stable_q, stable_d;
  logic [5:0]            stable_dly_q, stable_dly_d;
  logic [5:0][DB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [2:0]            operation_q, operation_d;
  rpt_state_e            state_q, state_d;
  logic [2:0]            trk_q, trk_d;
  logic [TM_W-1:0]       timer_q, timer_d;

  logic [5:0]            press;
  logic                  win_vld;
  logic [2:0]            win_idx;
  logic [TM_W-1:0]       timer_inc;
  logic                  repeat_due;

  // Synchroniser and per-button debounce; the stable level flips on the cycle
  // after the counter has already reached its limit.
  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    deb_cnt_d    = deb_cnt_q;
    for (int i = 0; i < 6; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DB_LAST) begin
        stable_d[i]  = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Rising edge of the stable level; scanning downward lets the lowest index win.
  always_comb begin
    press   = stable_q & ~stable_dly_q;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 5; i >= 0; i--) begin
      if (press[i]) begin
        win_vld = 1'b1;
        win_idx = 3'(i);
      end
    end
  end

  // Priority inside the repeat path: lock, fresh press, release, timer expiry.
  always_comb begin
    operation_d = '0;
    state_d     = state_q;
    trk_d       = trk_q;
    timer_d     = timer_q;
    timer_inc   = timer_q + TM_W'(1);
    repeat_due  = ((state_q == DELAY)  && (timer_inc == DELAY_LAST)) ||
                  ((state_q == REPEAT) && (timer_inc == PERIOD_LAST));
    if (lock) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (win_vld) begin
      operation_d = win_idx + 3'd1;
      timer_d     = '0;
      if (win_idx >= 3'd2) begin
        state_d = DELAY;
        trk_d   = win_idx;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q != IDLE) begin
      if (!stable_q[trk_q]) begin
        state_d = IDLE;
        timer_d = '0;
      end else if (repeat_due) begin
        operation_d = trk_q + 3'd1;
        state_d     = REPEAT;
        timer_d     = '0;
      end else begin
        timer_d = timer_inc;
      end
    end
  end

  // NOTE: the debounce counter array is cleared by reset like every other flop,
  // so a press half-way through debounce cannot surface after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      deb_cnt_q    <= '0;
      operation_q  <= '0;
      state_q      <= IDLE;
      trk_q        <= '0;
      timer_q      <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      deb_cnt_q    <= deb_cnt_d;
      operation_q  <= operation_d;
      state_q      <= state_d;
      trk_q        <= trk_d;
      timer_q      <= timer_d;
    end
  end

  assign operation = operation_q;

endmodule

// File: tb/tb_op_encoder.sv
// tb_op_encoder: directed bench for op_encoder with short debounce and repeat
// timings; every expected pulse cycle below is counted from the driving edge.
module tb_op_encoder;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       lock = 1'b0;
  logic [5:0] btn  = '0;
  logic [2:0] operation;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t        = 0;

  int got_cyc[$];
  int got_code[$];
  int exp_cyc[$];
  int exp_code[$];

  op_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .lock     (lock),
    .operation(operation)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each, logging non-zero codes.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (operation !== 3'd0) begin
        got_cyc.push_back(cyc);
        got_code.push_back(int'(operation));
      end
    end
  endtask

  task automatic expect_pulse(input int c, input int code);
    exp_cyc.push_back(c);
    exp_code.push_back(code);
  endtask

  task automatic clear_log();
    got_cyc.delete();
    got_code.delete();
    exp_cyc.delete();
    exp_code.delete();
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s pulse_count", tag), got_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < got_cyc.size(); i++) begin
      check($sformatf("%s pulse%0d_cycle", tag, i), got_cyc[i], exp_cyc[i]);
      check($sformatf("%s pulse%0d_code", tag, i), got_code[i], exp_code[i]);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check("reset_async_state", operation, 0);
    run(3);
    check("reset_held_state", operation, 0);
    rst = 1'b0;
    run(10);
    check("idle_after_reset", operation, 0);

    // Clean select press: raw step sampled at edge t+1, pulse after edge t+8.
    clear_log();
    t = cyc;
    btn[0] = 1'b1;
    expect_pulse(t + 8, 1);
    run(20);
    btn[0] = 1'b0;
    run(20);
    compare("clean_press");

    // Bouncing left button, then a held level released before the first repeat.
    clear_log();
    for (int s = 0; s < 3; s++) begin
      btn[2] = 1'b1;
      run(2);
      btn[2] = 1'b0;
      run(2);
    end
    t = cyc;
    btn[2] = 1'b1;
    expect_pulse(t + 8, 3);
    run(9);
    btn[2] = 1'b0;
    run(21);
    compare("bounce");

    // Held down button: first pulse, delay of 10, then every 5 until release.
    clear_log();
    t = cyc;
    btn[5] = 1'b1;
    expect_pulse(t + 8, 6);
    for (int k = 0; k < 6; k++) expect_pulse(t + 18 + 5 * k, 6);
    run(40);
    btn[5] = 1'b0;
    run(20);
    compare("auto_repeat");

    // Cancel and right together: cancel wins, right is dropped, no repeats.
    clear_log();
    t = cyc;
    btn[1] = 1'b1;
    btn[3] = 1'b1;
    expect_pulse(t + 8, 2);
    run(30);
    btn = '0;
    run(20);
    compare("simultaneous");

    // Up held with two repeats, then right pressed and preempts the tracking.
    clear_log();
    t = cyc;
    btn[4] = 1'b1;
    expect_pulse(t + 8, 5);
    expect_pulse(t + 18, 5);
    expect_pulse(t + 23, 5);
    run(19);
    btn[3] = 1'b1;
    expect_pulse(t + 27, 4);
    expect_pulse(t + 37, 4);
    expect_pulse(t + 42, 4);
    expect_pulse(t + 47, 4);
    expect_pulse(t + 52, 4);
    run(26);
    btn = '0;
    run(20);
    compare("preempt");

    // Press debounced while locked is swallowed and never re-emitted on unlock.
    clear_log();
    lock   = 1'b1;
    btn[0] = 1'b1;
    run(20);
    check("lock_hold", operation, 0);
    lock = 1'b0;
    run(20);
    btn[0] = 1'b0;
    run(15);
    compare("lock");

    // Reset asserted while a repeat pulse is on the output.
    clear_log();
    t = cyc;
    btn[5] = 1'b1;
    expect_pulse(t + 8, 6);
    expect_pulse(t + 18, 6);
    expect_pulse(t + 23, 6);
    run(23);
    check("pre_reset_pulse", operation, 6);
    #2;
    rst = 1'b1;
    btn = '0;
    #1 check("reset_mid_repeat_async", operation, 0);
    run(3);
    rst = 1'b0;
    run(30);
    compare("reset_mid_repeat");

    // A fresh press after reset is handled normally.
    clear_log();
    t = cyc;
    btn[0] = 1'b1;
    expect_pulse(t + 8, 1);
    run(15);
    btn[0] = 1'b0;
    run(15);
    compare("post_reset_press");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
